// File: rtl/alu_mult_seq_if.sv
// Start/ready handshake and operand/result bus between the execute stage
// and the sequential Booth multiplier.
interface alu_mult_seq_if;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        data_exception;
    logic        busy;

    modport master (
        output ctrl_MULT, data_operandA, data_operandB,
        input  data_result, data_resultRDY, data_exception, busy
    );

    modport slave (
        input  ctrl_MULT, data_operandA, data_operandB,
        output data_result, data_resultRDY, data_exception, busy
    );
endinterface

// File: rtl/alu_mult_seq.sv
// Radix-2 Booth multiplier: one add/sub per clock through the shared ALU,
// 32 iterations, low word of the product plus a 32-bit signed overflow flag.

module alu (
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [4:0]  ctrl_ALUopcode,
    input  logic [4:0]  ctrl_shiftamt,
    output logic [31:0] data_result,
    output logic        overflow
);
    always_comb begin
        data_result = '0;
        overflow    = 1'b0;
        case (ctrl_ALUopcode)
            5'b00000: begin
                data_result = data_operandA + data_operandB;
                overflow    = (data_operandA[31] == data_operandB[31]) &&
                              (data_result[31] != data_operandA[31]);
            end
            5'b00001: begin
                data_result = data_operandA - data_operandB;
                overflow    = (data_operandA[31] != data_operandB[31]) &&
                              (data_result[31] != data_operandA[31]);
            end
            5'b00010: data_result = data_operandA & data_operandB;
            5'b00011: data_result = data_operandA | data_operandB;
            5'b00100: data_result = data_operandA << ctrl_shiftamt;
            5'b00101: data_result = $signed(data_operandA) >>> ctrl_shiftamt;
            default:  data_result = '0;
        endcase
    end
endmodule

// state | meaning
// IDLE  | waiting for ctrl_MULT
// RUN   | Booth iterations in flight, busy=1
// DONE  | result registered, data_resultRDY pulse high
module alu_mult_seq (
    input  logic          clock,
    input  logic          resetn,
    alu_mult_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] m, p, q;
    logic        q_1;
    logic [5:0]  cnt;

    logic [4:0]  alu_op;
    logic [31:0] alu_res;
    logic        alu_ovf;
    logic        booth_op;
    logic [31:0] s;
    logic        sgn;
    logic [31:0] p_next, q_next;

    assign alu_op = (q[0] && !q_1) ? 5'b00001 : 5'b00000;

    alu u_alu (
        .data_operandA  (p),
        .data_operandB  (m),
        .ctrl_ALUopcode (alu_op),
        .ctrl_shiftamt  (5'd0),
        .data_result    (alu_res),
        .overflow       (alu_ovf)
    );

    // XOR with overflow recovers the true 33-bit sign, needed when M = 0x80000000
    always_comb begin
        booth_op = q[0] ^ q_1;
        s        = booth_op ? alu_res : p;
        sgn      = booth_op ? (alu_res[31] ^ alu_ovf) : p[31];
        p_next   = {sgn, s[31:1]};
        q_next   = {s[0], q[31:1]};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state              <= IDLE;
            m                  <= '0;
            p                  <= '0;
            q                  <= '0;
            q_1                <= 1'b0;
            cnt                <= '0;
            bus.busy           <= 1'b0;
            bus.data_resultRDY <= 1'b0;
            bus.data_exception <= 1'b0;
            bus.data_result    <= '0;
        end else begin
            bus.data_resultRDY <= 1'b0;
            if (bus.ctrl_MULT) begin
                // a start in any state (including mid-RUN) reloads and restarts
                state    <= RUN;
                m        <= bus.data_operandA;
                q        <= bus.data_operandB;
                p        <= '0;
                q_1      <= 1'b0;
                cnt      <= '0;
                bus.busy <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        p   <= p_next;
                        q   <= q_next;
                        q_1 <= q[0];
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state              <= DONE;
                            bus.busy           <= 1'b0;
                            bus.data_result    <= q_next;
                            bus.data_exception <= (p_next != {32{q_next[31]}});
                            bus.data_resultRDY <= 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
